// File: rtl/dbg_run_ctrl_if.sv
// Host/debug-side signal bundle for dbg_run_ctrl: run-control strobes,
// breakpoint write port, core PC observation and run-state status.
interface dbg_run_ctrl_if #(
  parameter int PC_W   = 32,
  parameter int NUM_BP = 4,
  parameter int STEP_W = 16
);
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

  // Run-control requests
  logic              halt_req;
  logic              step_req;
  logic              resume_req;
  logic [STEP_W-1:0] step_count;

  // Breakpoint write port
  logic              bp_wr;
  logic [IDX_W-1:0]  bp_idx;
  logic [PC_W-1:0]   bp_addr;
  logic              bp_en;

  // Core program counter
  logic [PC_W-1:0]   pc;
  logic              pc_valid;

  // Status
  logic              clk_en;
  logic              halted;
  logic              running;
  logic              stepping;
  logic [1:0]        halt_cause;
  logic [IDX_W-1:0]  bp_hit;
  logic              step_done;

  modport master (
    output halt_req, step_req, resume_req, step_count,
    output bp_wr, bp_idx, bp_addr, bp_en,
    output pc, pc_valid,
    input  clk_en, halted, running, stepping, halt_cause, bp_hit, step_done
  );

  modport slave (
    input  halt_req, step_req, resume_req, step_count,
    input  bp_wr, bp_idx, bp_addr, bp_en,
    input  pc, pc_valid,
    output clk_en, halted, running, stepping, halt_cause, bp_hit, step_done
  );
endinterface

// File: rtl/dbg_run_ctrl.sv
// Debug run controller: RUN / HALT / STEP state machine with hardware
// breakpoint comparators and a glitch-free gated core clock.
module dbg_run_ctrl #(
  parameter int PC_W   = 32,
  parameter int NUM_BP = 4,
  parameter int STEP_W = 16
) (
  input  logic          sys_clk,
  input  logic          reset,
  dbg_run_ctrl_if.slave bus,
  output logic          dbg_clk
);
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_HOST = 2'b01;
  localparam logic [1:0] CAUSE_BP   = 2'b10;
  localparam logic [1:0] CAUSE_STEP = 2'b11;

  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  // Status indicator bundle {halted, running, stepping, clk_en} for a state.
  function automatic logic [3:0] ind_of(state_e s);
    case (s)
      ST_HALT: ind_of = 4'b1000;
      ST_STEP: ind_of = 4'b0011;
      default: ind_of = 4'b0101;
    endcase
  endfunction

  state_e            state_q;
  logic [3:0]        ind_q;
  logic [1:0]        cause_q;
  logic [IDX_W-1:0]  bp_hit_q;
  logic              step_done_q;
  logic [STEP_W-1:0] cnt_q;
  logic              supp_q;
  logic              gate_q;

  logic [PC_W-1:0]   bp_addr_q [NUM_BP];
  logic              bp_en_q   [NUM_BP];

  logic              match_any;
  logic [IDX_W-1:0]  match_idx;
  logic              bp_fire;

  // Lowest enabled comparator whose address equals the current PC.
  always_comb begin
    // NOTE: combinational logic uses blocking assignments with a default
    // first, so every path assigns and no latch is inferred.
    match_any = 1'b0;
    match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en_q[i] && (bus.pc == bp_addr_q[i])) begin
        match_any = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  // A match only counts on a valid PC and outside the post-exit suppression window.
  assign bp_fire = bus.pc_valid && !supp_q && match_any;

  // Breakpoint comparator registers; an index with no comparator writes nothing.
  always_ff @(posedge sys_clk) begin
    // NOTE: this small register file is reset on purpose so all comparators
    // come up disabled; sequential state is updated with non-blocking '<='.
    if (reset) begin
      for (int i = 0; i < NUM_BP; i++) begin
        bp_addr_q[i] <= '0;
        bp_en_q[i]   <= 1'b0;
      end
    end else if (bus.bp_wr) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (bus.bp_idx == IDX_W'(i)) begin
          bp_addr_q[i] <= bus.bp_addr;
          bp_en_q[i]   <= bus.bp_en;
        end
      end
    end
  end

  // Run-control state machine with registered status outputs.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      ind_q       <= ind_of(ST_RUN);
      cause_q     <= CAUSE_NONE;
      bp_hit_q    <= '0;
      step_done_q <= 1'b0;
      cnt_q       <= '0;
      supp_q      <= 1'b0;
    end else begin
      step_done_q <= 1'b0;
      // The suppression window closes on the first valid PC after leaving HALT.
      if ((state_q != ST_HALT) && bus.pc_valid) begin
        supp_q <= 1'b0;
      end

      case (state_q)
        ST_HALT: begin
          if (bus.step_req) begin
            state_q <= ST_STEP;
            ind_q   <= ind_of(ST_STEP);
            cnt_q   <= (bus.step_count == '0) ? STEP_ONE : bus.step_count;
            supp_q  <= 1'b1;
          end else if (bus.resume_req) begin
            state_q <= ST_RUN;
            ind_q   <= ind_of(ST_RUN);
            cause_q <= CAUSE_NONE;
            supp_q  <= 1'b1;
          end
        end

        ST_RUN, ST_STEP: begin
          if (bus.halt_req) begin
            state_q <= ST_HALT;
            ind_q   <= ind_of(ST_HALT);
            cause_q <= CAUSE_HOST;
            cnt_q   <= '0;
          end else if (bp_fire) begin
            state_q  <= ST_HALT;
            ind_q    <= ind_of(ST_HALT);
            cause_q  <= CAUSE_BP;
            bp_hit_q <= match_idx;
            cnt_q    <= '0;
          end else if (state_q == ST_STEP) begin
            if (cnt_q == STEP_ONE) begin
              state_q     <= ST_HALT;
              ind_q       <= ind_of(ST_HALT);
              cause_q     <= CAUSE_STEP;
              step_done_q <= 1'b1;
              cnt_q       <= '0;
            end else begin
              cnt_q <= cnt_q - STEP_ONE;
            end
          end
        end

        default: begin
          state_q <= ST_RUN;
          ind_q   <= ind_of(ST_RUN);
        end
      endcase
    end
  end

  // Re-time the enable into the low phase so the AND gate never chops a high pulse.
  always_ff @(negedge sys_clk) begin
    gate_q <= ind_q[0];
  end

  assign dbg_clk = sys_clk & gate_q;

  assign bus.halted     = ind_q[3];
  assign bus.running    = ind_q[2];
  assign bus.stepping   = ind_q[1];
  assign bus.clk_en     = ind_q[0];
  assign bus.halt_cause = cause_q;
  assign bus.bp_hit     = bp_hit_q;
  assign bus.step_done  = step_done_q;
endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Self-checking bench for dbg_run_ctrl: directed vector table, multi-cycle
// clock-pulse sequences, and random stimulus against a behavioural model.
module tb_dbg_run_ctrl;
  localparam int PC_W   = 32;
  localparam int NUM_BP = 3;
  localparam int STEP_W = 16;

  logic sys_clk;
  logic reset;
  logic dbg_clk;

  dbg_run_ctrl_if #(.PC_W(PC_W), .NUM_BP(NUM_BP), .STEP_W(STEP_W)) bus ();

  dbg_run_ctrl #(.PC_W(PC_W), .NUM_BP(NUM_BP), .STEP_W(STEP_W)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus),
    .dbg_clk (dbg_clk)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_pass  = 0;
  int n_total = 0;

  int pulses    = 0;
  int done_seen = 0;
  always @(posedge dbg_clk) pulses++;
  always @(negedge sys_clk) if (bus.step_done === 1'b1) done_seen++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
  endtask

  // Observed status: {halted, running, stepping, clk_en, cause[1:0], bp_hit[1:0], step_done}
  function automatic logic [8:0] dut_obs();
    return {bus.halted, bus.running, bus.stepping, bus.clk_en,
            bus.halt_cause, bus.bp_hit, bus.step_done};
  endfunction

  localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;

  function automatic logic [8:0] exp_of(int mode, int cause, int hit, bit sd);
    logic [1:0] c, h;
    c = cause[1:0];
    h = hit[1:0];
    return {mode == M_HALT, mode == M_RUN, mode == M_STEP, mode != M_HALT, c, h, sd};
  endfunction

  typedef struct {
    logic              rst, halt, step, resume;
    logic [STEP_W-1:0] cnt;
    logic              pv;
    logic [PC_W-1:0]   pc;
    logic              wr;
    logic [1:0]        idx;
    logic [PC_W-1:0]   addr;
    logic              en;
    logic [8:0]        exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit halt, input bit step, input bit resume,
                     input int cnt, input bit pv, input int pc,
                     input bit wr, input int idx, input int addr, input bit en,
                     input int em, input int ec, input int eh, input bit ed);
    vec_t v;
    v.rst = rst; v.halt = halt; v.step = step; v.resume = resume;
    v.cnt = STEP_W'(cnt); v.pv = pv; v.pc = PC_W'(pc);
    v.wr = wr; v.idx = 2'(idx); v.addr = PC_W'(addr); v.en = en;
    v.exp = exp_of(em, ec, eh, ed);
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset          = v.rst;
    bus.halt_req   = v.halt;
    bus.step_req   = v.step;
    bus.resume_req = v.resume;
    bus.step_count = v.cnt;
    bus.pc_valid   = v.pv;
    bus.pc         = v.pc;
    bus.bp_wr      = v.wr;
    bus.bp_idx     = v.idx;
    bus.bp_addr    = v.addr;
    bus.bp_en      = v.en;
  endtask

  task automatic idle();
    reset = 0; bus.halt_req = 0; bus.step_req = 0; bus.resume_req = 0;
    bus.step_count = '0; bus.pc_valid = 0; bus.pc = '0;
    bus.bp_wr = 0; bus.bp_idx = '0; bus.bp_addr = '0; bus.bp_en = 0;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  int              m_mode, m_left, m_cause, m_hit;
  bit              m_done, m_skip;
  logic [PC_W-1:0] m_addr [NUM_BP];
  bit              m_en   [NUM_BP];

  // Applies the run-control rules for one clock edge using the inputs now on the bus.
  task automatic model_edge();
    int first;
    first = -1;
    if (reset) begin
      m_mode = M_RUN; m_left = 0; m_cause = 0; m_hit = 0; m_done = 0; m_skip = 0;
      for (int i = 0; i < NUM_BP; i++) begin m_addr[i] = '0; m_en[i] = 0; end
    end else begin
      for (int i = 0; i < NUM_BP; i++)
        if (first < 0 && bus.pc_valid && !m_skip && m_en[i] && m_addr[i] == bus.pc) first = i;
      m_done = 0;
      if (m_mode != M_HALT && bus.pc_valid) m_skip = 0;
      if (m_mode == M_HALT) begin
        if (bus.step_req) begin
          m_mode = M_STEP;
          m_left = (bus.step_count == 0) ? 1 : int'(bus.step_count);
          m_skip = 1;
        end else if (bus.resume_req) begin
          m_mode = M_RUN; m_cause = 0; m_skip = 1;
        end
      end else if (bus.halt_req) begin
        m_mode = M_HALT; m_cause = 1;
      end else if (first >= 0) begin
        m_mode = M_HALT; m_cause = 2; m_hit = first;
      end else if (m_mode == M_STEP) begin
        m_left--;
        if (m_left == 0) begin m_mode = M_HALT; m_cause = 3; m_done = 1; end
      end
      if (bus.bp_wr && int'(bus.bp_idx) < NUM_BP) begin
        m_addr[bus.bp_idx] = bus.bp_addr;
        m_en[bus.bp_idx]   = bus.bp_en;
      end
    end
  endtask

  initial begin
    idle();
    //    rst h s r cnt pv  pc     wr idx addr  en   mode    c  hit sd
    add(1, 0,0,0, 0, 0, 0,     0, 0, 0,     0,   M_RUN,  0, 0, 0); // r0 reset
    add(0, 1,0,0, 0, 0, 0,     0, 0, 0,     0,   M_HALT, 1, 0, 0); // r1 host halt
    add(0, 0,0,0, 0, 0, 0,     0, 0, 0,     0,   M_HALT, 1, 0, 0);
    add(0, 0,0,0, 0, 0, 0,     1, 2, 'h100, 1,   M_HALT, 1, 0, 0); // comp2 = 0x100
    add(0, 0,0,0, 0, 0, 0,     1, 1, 'h100, 1,   M_HALT, 1, 0, 0); // comp1 = 0x100
    add(0, 0,0,1, 0, 0, 0,     0, 0, 0,     0,   M_RUN,  0, 0, 0); // r5 resume
    add(0, 0,0,0, 0, 1, 'h50,  0, 0, 0,     0,   M_RUN,  0, 0, 0); // consumes suppression
    add(0, 0,0,0, 0, 1, 'h100, 0, 0, 0,     0,   M_HALT, 2, 1, 0); // r7 lowest index wins
    add(0, 0,0,1, 0, 0, 0,     0, 0, 0,     0,   M_RUN,  0, 1, 0);
    add(0, 0,0,0, 0, 1, 'h100, 0, 0, 0,     0,   M_RUN,  0, 1, 0); // r9 suppressed
    add(0, 0,0,0, 0, 1, 'h100, 0, 0, 0,     0,   M_HALT, 2, 1, 0);
    add(0, 0,0,1, 0, 0, 0,     0, 0, 0,     0,   M_RUN,  0, 1, 0);
    add(0, 0,0,0, 0, 1, 'h200, 0, 0, 0,     0,   M_RUN,  0, 1, 0);
    add(0, 0,0,0, 0, 1, 'h100, 1, 1, 'h100, 0,   M_HALT, 2, 1, 0); // r13 compare sees old comp1
    add(0, 0,0,1, 0, 0, 0,     0, 0, 0,     0,   M_RUN,  0, 1, 0);
    add(0, 0,0,0, 0, 1, 'h300, 0, 0, 0,     0,   M_RUN,  0, 1, 0);
    add(0, 0,0,0, 0, 1, 'h100, 0, 0, 0,     0,   M_HALT, 2, 2, 0); // r16 comp1 now disabled
    add(0, 0,0,1, 0, 0, 0,     0, 0, 0,     0,   M_RUN,  0, 2, 0);
    add(0, 0,0,0, 0, 1, 0,     0, 0, 0,     0,   M_RUN,  0, 2, 0);
    add(0, 1,0,0, 0, 1, 'h100, 0, 0, 0,     0,   M_HALT, 1, 2, 0); // r19 halt beats bp
    add(0, 0,1,1, 5, 0, 0,     0, 0, 0,     0,   M_STEP, 1, 2, 0); // r20 step beats resume
    add(0, 0,0,0, 0, 0, 0,     0, 0, 0,     0,   M_STEP, 1, 2, 0);
    add(0, 0,0,1, 0, 0, 0,     0, 0, 0,     0,   M_STEP, 1, 2, 0); // resume ignored
    add(0, 0,1,0, 2, 0, 0,     0, 0, 0,     0,   M_STEP, 1, 2, 0); // step ignored
    add(0, 0,0,0, 0, 0, 0,     0, 0, 0,     0,   M_STEP, 1, 2, 0);
    add(0, 0,0,0, 0, 0, 0,     0, 0, 0,     0,   M_HALT, 3, 2, 1); // r25 step complete
    add(0, 0,0,0, 0, 0, 0,     0, 0, 0,     0,   M_HALT, 3, 2, 0);
    add(0, 0,0,0, 0, 0, 0,     1, 3, 'h300, 1,   M_HALT, 3, 2, 0); // idx 3: no comparator
    add(0, 0,0,1, 0, 0, 0,     0, 0, 0,     0,   M_RUN,  0, 2, 0);
    add(0, 0,0,0, 0, 1, 'h400, 0, 0, 0,     0,   M_RUN,  0, 2, 0);
    add(0, 0,0,0, 0, 1, 'h300, 0, 0, 0,     0,   M_RUN,  0, 2, 0); // r30 no halt
    add(0, 0,1,0, 2, 0, 0,     0, 0, 0,     0,   M_RUN,  0, 2, 0); // step ignored in RUN
    add(0, 0,0,1, 0, 0, 0,     0, 0, 0,     0,   M_RUN,  0, 2, 0);
    add(0, 1,0,0, 0, 0, 0,     0, 0, 0,     0,   M_HALT, 1, 2, 0);
    add(0, 0,1,0, 4, 0, 0,     0, 0, 0,     0,   M_STEP, 1, 2, 0);
    add(0, 0,0,0, 0, 1, 'h100, 0, 0, 0,     0,   M_STEP, 1, 2, 0); // suppressed in STEP
    add(0, 0,0,0, 0, 1, 'h100, 0, 0, 0,     0,   M_HALT, 2, 2, 0); // bp aborts step
    add(0, 0,1,0, 1, 0, 0,     0, 0, 0,     0,   M_STEP, 2, 2, 0);
    add(0, 1,0,0, 0, 0, 0,     0, 0, 0,     0,   M_HALT, 1, 2, 0); // abort beats completion

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      tick();
      check($sformatf("vec%0d", i), 64'(dut_obs()), 64'(tbl[i].exp));
    end
    idle();

    // Step of 3 then step of 0: count gated pulses.
    tick();
    pulses = 0; done_seen = 0;
    bus.step_req = 1; bus.step_count = 3; tick(); idle();
    repeat (6) tick();
    check("step3_pulses", 64'(pulses), 64'd3);
    check("step3_done", 64'(done_seen), 64'd1);
    check("step3_cause", 64'(bus.halt_cause), 64'd3);
    pulses = 0; done_seen = 0;
    bus.step_req = 1; bus.step_count = 0; tick(); idle();
    repeat (5) tick();
    check("step0_pulses", 64'(pulses), 64'd1);
    check("step0_done", 64'(done_seen), 64'd1);

    // Host halt from RUN stops the gated clock.
    bus.resume_req = 1; tick(); idle();
    repeat (3) tick();
    bus.halt_req = 1; tick(); idle();
    check("halt_state", 64'({bus.halted, bus.clk_en, bus.halt_cause}), 64'b1001);
    pulses = 0;
    repeat (5) tick();
    check("halt_no_pulses", 64'(pulses), 64'd0);

    // Step of 10 aborted by halt_req in its 4th cycle.
    pulses = 0; done_seen = 0;
    bus.step_req = 1; bus.step_count = 10; tick(); idle();
    repeat (3) tick();
    bus.halt_req = 1; tick(); idle();
    check("abort_halted", 64'(bus.halted), 64'd1);
    repeat (4) tick();
    check("abort_pulses", 64'(pulses), 64'd4);
    check("abort_cause", 64'(bus.halt_cause), 64'd1);
    check("abort_no_done", 64'(done_seen), 64'd0);

    // Reset in the middle of a step (comparator 2 still armed at 0x100).
    done_seen = 0;
    bus.step_req = 1; bus.step_count = 10; tick(); idle();
    repeat (3) tick();
    reset = 1; tick(); idle();
    check("rst_state", 64'({bus.running, bus.halted, bus.stepping, bus.clk_en, bus.step_done}), 64'b10010);
    pulses = 0;
    bus.pc_valid = 1; bus.pc = 'h100;
    repeat (3) tick();
    idle();
    check("rst_bp_cleared", 64'(bus.running), 64'd1);
    check("rst_pulses", 64'(pulses), 64'd3);
    repeat (3) tick();
    check("rst_no_done", 64'(done_seen), 64'd0);

    // Random stimulus against the model.
    reset = 1; model_edge(); tick(); idle();
    check("rnd_reset", 64'(dut_obs()), 64'(exp_of(m_mode, m_cause, m_hit, m_done)));
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 63) == 0);
      bus.halt_req   = ($urandom_range(0, 9) == 0);
      bus.step_req   = ($urandom_range(0, 9) == 0);
      bus.resume_req = ($urandom_range(0, 6) == 0);
      bus.step_count = STEP_W'($urandom_range(0, 5));
      bus.bp_wr      = ($urandom_range(0, 9) == 0);
      bus.bp_idx     = 2'($urandom_range(0, 3));
      bus.bp_addr    = PC_W'($urandom_range(1, 3) * 16);
      bus.bp_en      = 1'($urandom_range(0, 1));
      bus.pc_valid   = 1'($urandom_range(0, 1));
      bus.pc         = PC_W'($urandom_range(1, 3) * 16);
      model_edge();
      tick();
      check($sformatf("rnd%0d", n), 64'(dut_obs()), 64'(exp_of(m_mode, m_cause, m_hit, m_done)));
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
